tx_frontend: RTL and testbench

Serial transmit front end of the UART. It accepts one data word per handshake from the TX FIFO/register side and serialises it onto `uart_tx_o` as start bit, data bits (LSB first), optional parity, and one or two stop bits. Frame format and baud rate come from the same control-register fields the receive front end uses, so a loopback of `uart_tx_o` into the receiver recovers the word and its parity.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/tx_frontend.sv | 134 +++++++++++++
 tb/tb_tx_frontend.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Used by both the transmit and receive front ends.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT
  } tx_state_t;

  localparam int MIN_FRAME_SIZE = 8;
  localparam int MAX_FRAME_SIZE = 11;

  // Bits following the start bit: data + parity + stop.
  function automatic logic [3:0] frame_size(
    input logic       ds,
    input logic [1:0] p,
    input logic       s
  );
    logic [3:0] n;
    n = 4'd8 + {3'b000, ds}
             + {3'b000, (p != 2'b00)}
             + {3'b000, s};
    return n;
  endfunction

endpackage

// File: rtl/tx_frontend.sv
// UART transmit front end.
// Serialises start, data (LSB first), parity, stop bits.
module tx_frontend (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] cr_clk_div_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        uart_tx_o,
  output logic        done_o
);

  import uart_pkg::*;

  tx_state_t state_q, state_d;

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  bits_q, bits_d;
  logic [MAX_FRAME_SIZE-1:0] shift_q, shift_d;
  logic [MAX_FRAME_SIZE-1:0] frame;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic [15:0] div_in;
  logic        par;
  logic [3:0]  pos;

  assign div_in = (cr_clk_div_i == 16'd0) ? 16'd1
                                          : cr_clk_div_i;

  assign par = cr_p_i[0]
             ^ (^data_i[6:0])
             ^ (cr_ds_i & data_i[7]);

  // Assemble post-start bits: data, parity, stops, zero pad.
  always_comb begin
    frame    = '0;
    frame[6:0] = data_i[6:0];
    frame[7] = cr_ds_i & data_i[7];
    pos      = cr_ds_i ? 4'd8 : 4'd7;
    if (cr_p_i != 2'b00) begin
      frame[pos] = par;
      pos        = pos + 4'd1;
    end
    frame[pos] = 1'b1;
    if (cr_s_i) frame[pos + 4'd1] = 1'b1;
  end

  // Next-state, baud counter and shift register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = START;
          div_d   = div_in;
          cnt_d   = div_in - 16'd1;
          bits_d  = frame_size(cr_ds_i, cr_p_i, cr_s_i)
                  - 4'd1;
          shift_d = frame;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d = SHIFT;
          cnt_d   = div_q - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == 16'd0) begin
          if (bits_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            shift_d = {1'b1,
                       shift_q[MAX_FRAME_SIZE-1:1]};
            bits_d  = bits_q - 4'd1;
            cnt_d   = div_q - 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value for the upcoming state, registered below.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      SHIFT:   tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign uart_tx_o = tx_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_tx_frontend.sv
// Directed bench for tx_frontend.
// Table vectors plus reset, back-to-back and loopback sequences.
module tb_tx_frontend;

  logic        clk;
  logic        rst_n;
  logic [15:0] cr_clk_div;
  logic        cr_ds;
  logic [1:0]  cr_p;
  logic        cr_s;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        uart_tx;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] div;
    logic        ds;
    logic [1:0]  p;
    logic        s;
    logic [7:0]  data;
    int          bit_len;
    int          fs;
    logic [10:0] bits;
    int          total;
  } vec_t;

  vec_t vecs[10];

  tx_frontend dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cr_clk_div_i(cr_clk_div),
    .cr_ds_i     (cr_ds),
    .cr_p_i      (cr_p),
    .cr_s_i      (cr_s),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .uart_tx_o   (uart_tx),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   nbad_line;
    int   nbad_rdy;
    int   nbad_done;
    int   bitn;
    logic exp;
    nbad_line = 0;
    nbad_rdy  = 0;
    nbad_done = 0;
    check($sformatf("v%0d ready before", idx), ready, 1);
    cr_clk_div = v.div;
    cr_ds      = v.ds;
    cr_p       = v.p;
    cr_s       = v.s;
    data       = v.data;
    valid      = 1'b1;
    step();
    valid = 1'b0;
    data  = ~v.data;
    for (int t = 1; t <= v.total; t++) begin
      bitn = (t - 1) / v.bit_len;
      exp  = (bitn == 0) ? 1'b0 : v.bits[bitn-1];
      if (uart_tx !== exp) nbad_line++;
      if (ready !== 1'b0) nbad_rdy++;
      if (done !== 1'b0) nbad_done++;
      if (t == 2) begin
        cr_clk_div = v.div + 16'd5;
        cr_ds      = ~v.ds;
        cr_p       = ~v.p;
        cr_s       = ~v.s;
      end
      step();
    end
    check($sformatf("v%0d line errors", idx), nbad_line, 0);
    check($sformatf("v%0d ready high mid", idx), nbad_rdy, 0);
    check($sformatf("v%0d early done", idx), nbad_done, 0);
    check($sformatf("v%0d end done/ready/line", idx),
          {done, ready, uart_tx}, 3'b111);
    step();
    check($sformatf("v%0d done one cycle", idx), done, 0);
  endtask

  task automatic loopback(input int c);
    logic       ds;
    logic [1:0] p;
    logic       s;
    logic [7:0] d;
    logic [7:0] rx;
    logic [7:0] dm;
    logic       cap[0:255];
    int         nd;
    int         fs;
    int         total;
    int         ones;
    logic       pb;
    logic       stops_ok;
    ds = c[0];
    p  = c[2:1];
    s  = c[3];
    d  = 8'h35 + 8'(c * 29);
    nd = ds ? 8 : 7;
    fs = nd + ((p != 2'b00) ? 1 : 0) + (s ? 2 : 1);
    total = 16 * (1 + fs);
    cr_clk_div = 16'd16;
    cr_ds = ds;
    cr_p  = p;
    cr_s  = s;
    data  = d;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int t = 1; t <= total + 1; t++) begin
      cap[t] = uart_tx;
      if (t == total + 1)
        check($sformatf("lb%0d done", c), done, 1);
      step();
    end
    rx = 8'h00;
    for (int i = 0; i < nd; i++)
      rx[i] = cap[(i + 1) * 16 + 8];
    dm = ds ? d : {1'b0, d[6:0]};
    check($sformatf("lb%0d start", c), cap[8], 0);
    check($sformatf("lb%0d data", c), rx, dm);
    if (p != 2'b00) begin
      ones = $countones(dm);
      pb   = (p == 2'b10) ? ones[0] : ~ones[0];
      check($sformatf("lb%0d parity", c),
            cap[(nd + 1) * 16 + 8], pb);
    end
    stops_ok = 1'b1;
    for (int i = fs - (s ? 1 : 0); i <= fs; i++)
      if (cap[i * 16 + 8] !== 1'b1) stops_ok = 1'b0;
    check($sformatf("lb%0d stops", c), stops_ok, 1);
  endtask

  initial begin
    int   nbad;
    int   ndone;
    logic [31:0] dmask;
    logic exp;

    vecs[0] = '{16'd4, 1'b1, 2'd0, 1'b0, 8'h55, 4, 9,  11'h155, 40};
    vecs[1] = '{16'd2, 1'b1, 2'd1, 1'b0, 8'hA5, 2, 10, 11'h3A5, 22};
    vecs[2] = '{16'd2, 1'b1, 2'd2, 1'b0, 8'hA5, 2, 10, 11'h2A5, 22};
    vecs[3] = '{16'd2, 1'b1, 2'd0, 1'b1, 8'hA5, 2, 10, 11'h3A5, 22};
    vecs[4] = '{16'd2, 1'b1, 2'd1, 1'b1, 8'hA5, 2, 11, 11'h7A5, 24};
    vecs[5] = '{16'd3, 1'b0, 2'd2, 1'b0, 8'hFF, 3, 9,  11'h1FF, 30};
    vecs[6] = '{16'd3, 1'b0, 2'd1, 1'b0, 8'h80, 3, 9,  11'h180, 30};
    vecs[7] = '{16'd0, 1'b1, 2'd0, 1'b0, 8'h3C, 1, 9,  11'h13C, 10};
    vecs[8] = '{16'd1, 1'b0, 2'd0, 1'b1, 8'h2A, 1, 9,  11'h1AA, 10};
    vecs[9] = '{16'd2, 1'b0, 2'd3, 1'b1, 8'h00, 2, 10, 11'h380, 22};

    rst_n      = 1'b0;
    valid      = 1'b1;
    data       = 8'h00;
    cr_clk_div = 16'd1;
    cr_ds      = 1'b1;
    cr_p       = 2'b00;
    cr_s       = 1'b0;
    step();
    step();
    step();
    check("reset line", uart_tx, 1);
    check("reset ready", ready, 1);
    check("reset done", done, 0);
    rst_n = 1'b1;
    valid = 1'b0;
    step();
    check("idle line", uart_tx, 1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // back-to-back at div=1 with cr_s toggled mid-frame
    cr_clk_div = 16'd1;
    cr_ds = 1'b1;
    cr_p  = 2'b00;
    cr_s  = 1'b0;
    data  = 8'h00;
    valid = 1'b1;
    nbad  = 0;
    ndone = 0;
    dmask = '0;
    step();
    for (int t = 1; t <= 24; t++) begin
      if (t <= 9) exp = 1'b0;
      else if (t == 12) exp = 1'b0;
      else exp = 1'b1;
      if (uart_tx !== exp) nbad++;
      if (done === 1'b1) begin
        ndone++;
        dmask[t] = 1'b1;
      end
      if (t == 3) cr_s = 1'b1;
      if (t == 11) begin
        cr_s = 1'b0;
        data = 8'hFF;
      end
      if (t == 12) valid = 1'b0;
      step();
    end
    check("b2b line errors", nbad, 0);
    check("b2b done count", ndone, 2);
    check("b2b done timing", dmask,
          (32'd1 << 11) | (32'd1 << 22));

    // reset during data bit 3 at div=8
    cr_clk_div = 16'd8;
    cr_ds = 1'b1;
    cr_p  = 2'b00;
    cr_s  = 1'b0;
    data  = 8'hF7;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int t = 1; t < 35; t++) step();
    check("bit3 on line", uart_tx, 0);
    rst_n = 1'b0;
    step();
    check("rst line", uart_tx, 1);
    check("rst ready", ready, 1);
    check("rst done", done, 0);
    rst_n = 1'b1;
    nbad  = 0;
    for (int t = 0; t < 100; t++) begin
      if (done !== 1'b0 || uart_tx !== 1'b1) nbad++;
      step();
    end
    check("abandoned frame quiet", nbad, 0);
    run_vec(vecs[0], 10);

    for (int c = 0; c < 16; c++) loopback(c);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
